// File: rtl/forward_scoreboard.sv
// Operand-forwarding scoreboard. It tracks the register writers that are in flight behind ID and
// produces per-operand forward selects plus a load-use / multi-cycle hazard stall.
module forward_scoreboard #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned DEPTH   = 3,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned CNT_W   = 32,
  localparam int unsigned SW     = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs_addr,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic [REG_AW-1:0]         id_rd_addr,
  input  logic                      id_rd_wen,
  input  logic [SW-1:0]             id_rdy_stage,
  input  logic                      ext_stall,
  input  logic [DEPTH-1:0]          flush_mask,
  output logic [NUM_SRC*SW-1:0]     fwd_sel,
  output logic                      hazard_stall,
  output logic [CNT_W-1:0]          stall_cycles
);

  logic [DEPTH-1:0]  e_valid;
  logic [DEPTH-1:0]  e_wen;
  logic [REG_AW-1:0] e_rd  [DEPTH];
  logic [SW-1:0]     e_rdy [DEPTH];

  logic [NUM_SRC*SW-1:0] sel_c;
  logic                  stall_c;
  logic [REG_AW-1:0]     rs;
  logic                  hit;
  logic [SW-1:0]         ksel;
  logic [SW-1:0]         need;

  // The stage scan runs oldest to youngest so the youngest hit overwrites and wins.
  always_comb begin
    sel_c   = '0;
    stall_c = 1'b0;
    rs      = '0;
    hit     = 1'b0;
    ksel    = '0;
    need    = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      rs   = id_rs_addr[i*REG_AW +: REG_AW];
      hit  = 1'b0;
      ksel = '0;
      need = '0;
      for (int unsigned k = DEPTH; k > 0; k--) begin
        if (id_valid && id_rs_used[i] && e_valid[k-1] && e_wen[k-1] &&
            (e_rd[k-1] != '0) && (e_rd[k-1] == rs)) begin
          hit  = 1'b1;
          ksel = SW'(k);
          need = e_rdy[k-1];
        end
      end
      sel_c[i*SW +: SW] = ksel;
      if (hit && (ksel < need))
        stall_c = 1'b1;
    end
  end

  assign fwd_sel      = sel_c;
  assign hazard_stall = stall_c;

  // A flush bit kills the entry that occupied that stage before the edge, whether it moves or holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_valid      <= '0;
      stall_cycles <= '0;
    end else if (!ext_stall) begin
      for (int unsigned k = 1; k < DEPTH; k++) begin
        e_valid[k] <= e_valid[k-1] & ~flush_mask[k-1];
        e_wen[k]   <= e_wen[k-1];
        e_rd[k]    <= e_rd[k-1];
        e_rdy[k]   <= e_rdy[k-1];
      end
      e_valid[0] <= id_valid & ~stall_c & ~flush_mask[0];
      e_wen[0]   <= id_rd_wen;
      e_rd[0]    <= id_rd_addr;
      e_rdy[0]   <= id_rdy_stage;
      if (stall_c && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end else begin
      e_valid <= e_valid & ~flush_mask;
    end
  end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Scoreboard bench for forward_scoreboard: the driver queues hand-computed expectations for each
// driven cycle, and a negedge monitor pops them and compares them against the DUT outputs.
module tb_forward_scoreboard;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [9:0] id_rs_addr = '0;
  logic [1:0] id_rs_used = '0;
  logic [4:0] id_rd_addr = '0;
  logic       id_rd_wen = 1'b0;
  logic [1:0] id_rdy_stage = '0;
  logic       ext_stall = 1'b0;
  logic [2:0] flush_mask = '0;
  logic [3:0] fwd_sel;
  logic       hazard_stall;
  logic [2:0] stall_cycles;

  logic rst_drv = 1'b1;

  forward_scoreboard #(.NUM_SRC(2), .DEPTH(3), .REG_AW(5), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
    .id_rs_used(id_rs_used), .id_rd_addr(id_rd_addr), .id_rd_wen(id_rd_wen),
    .id_rdy_stage(id_rdy_stage), .ext_stall(ext_stall), .flush_mask(flush_mask),
    .fwd_sel(fwd_sel), .hazard_stall(hazard_stall), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] s0;
    logic [1:0] s1;
    logic       st;
    logic [2:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_cmp++;
      if (fwd_sel !== {e.s1, e.s0}) begin
        n_bad++;
        $display("FAIL %s fwd_sel got=%b exp=%b", e.name, fwd_sel, {e.s1, e.s0});
      end
      n_cmp++;
      if (hazard_stall !== e.st) begin
        n_bad++;
        $display("FAIL %s hazard_stall got=%b exp=%b", e.name, hazard_stall, e.st);
      end
      n_cmp++;
      if (stall_cycles !== e.cnt) begin
        n_bad++;
        $display("FAIL %s stall_cycles got=%0d exp=%0d", e.name, stall_cycles, e.cnt);
      end
    end
  end

  task automatic step(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                      input logic [1:0] used, input logic [4:0] rd, input logic wen,
                      input logic [1:0] rdy, input logic ext, input logic [2:0] fl);
    @(posedge clk);
    #1;
    rst          = rst_drv;
    id_valid     = v;
    id_rs_addr   = {r1, r0};
    id_rs_used   = used;
    id_rd_addr   = rd;
    id_rd_wen    = wen;
    id_rdy_stage = rdy;
    ext_stall    = ext;
    flush_mask   = fl;
  endtask

  task automatic expect_now(input string name, input logic [1:0] s0, input logic [1:0] s1,
                            input logic st, input logic [2:0] cnt);
    exp_t e;
    e.name = name;
    e.s0   = s0;
    e.s1   = s1;
    e.st   = st;
    e.cnt  = cnt;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 2'd0, 1'b0, 3'b000);
  endtask

  function automatic logic [2:0] sat(input int v);
    return (v > 7) ? 3'd7 : 3'(v);
  endfunction

  initial begin
    int c;
    // reset, then idle
    idle(2);
    rst_drv = 1'b0;
    idle(1);
    expect_now("reset", 2'd0, 2'd0, 1'b0, 3'd0);

    // ALU write x5 forwarded from EX, then from MEM
    step(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 2'd1, 1'b0, 3'b000);
    step(1'b1, 5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0, 3'b000);
    expect_now("alu_ex", 2'd1, 2'd0, 1'b0, 3'd0);
    step(1'b1, 5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0, 3'b000);
    expect_now("alu_mem", 2'd2, 2'd0, 1'b0, 3'd0);
    idle(3);

    // load-use on operand 1
    step(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 2'd2, 1'b0, 3'b000);
    step(1'b1, 5'd0, 5'd7, 2'b10, 5'd0, 1'b0, 2'd0, 1'b0, 3'b000);
    expect_now("load_use_stall", 2'd0, 2'd1, 1'b1, 3'd0);
    step(1'b1, 5'd0, 5'd7, 2'b10, 5'd0, 1'b0, 2'd0, 1'b0, 3'b000);
    expect_now("load_use_fwd", 2'd0, 2'd2, 1'b0, 3'd1);
    idle(3);

    // back-to-back writers of x3: youngest wins on both operands
    step(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 2'd1, 1'b0, 3'b000);
    step(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 2'd1, 1'b0, 3'b000);
    step(1'b1, 5'd3, 5'd3, 2'b11, 5'd0, 1'b0, 2'd0, 1'b0, 3'b000);
    expect_now("dup_youngest", 2'd1, 2'd1, 1'b0, 3'd1);
    idle(3);

    // x0 never hits; unused operands never hit
    step(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 2'd2, 1'b0, 3'b000);
    step(1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 1'b0, 2'd0, 1'b0, 3'b000);
    expect_now("x0_read", 2'd0, 2'd0, 1'b0, 3'd1);
    idle(3);
    step(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 2'd1, 1'b0, 3'b000);
    step(1'b1, 5'd4, 5'd4, 2'b00, 5'd0, 1'b0, 2'd0, 1'b0, 3'b000);
    expect_now("unused_ops", 2'd0, 2'd0, 1'b0, 3'd1);
    step(1'b1, 5'd4, 5'd4, 2'b10, 5'd0, 1'b0, 2'd0, 1'b0, 3'b000);
    expect_now("one_used", 2'd0, 2'd2, 1'b0, 3'd1);
    idle(3);

    // flush of EX entry removes the load
    step(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 2'd2, 1'b0, 3'b000);
    step(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 2'd0, 1'b0, 3'b001);
    expect_now("flush_cycle", 2'd0, 2'd0, 1'b0, 3'd1);
    step(1'b1, 5'd9, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0, 3'b000);
    expect_now("after_flush", 2'd0, 2'd0, 1'b0, 3'd1);
    idle(3);

    // flush_mask[0] suppresses insertion of the ID instruction
    step(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 2'd1, 1'b0, 3'b001);
    step(1'b1, 5'd6, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0, 3'b000);
    expect_now("flush_id", 2'd0, 2'd0, 1'b0, 3'd1);
    idle(3);

    // flush wins over ext_stall
    step(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 2'd2, 1'b0, 3'b000);
    step(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 2'd0, 1'b1, 3'b001);
    step(1'b1, 5'd9, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0, 3'b000);
    expect_now("flush_over_ext", 2'd0, 2'd0, 1'b0, 3'd1);
    idle(3);

    // ext_stall holds entries and freezes the counter
    step(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 2'd2, 1'b0, 3'b000);
    step(1'b1, 5'd9, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b1, 3'b000);
    expect_now("ext_hold_a", 2'd1, 2'd0, 1'b1, 3'd1);
    step(1'b1, 5'd9, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b1, 3'b000);
    expect_now("ext_hold_b", 2'd1, 2'd0, 1'b1, 3'd1);
    step(1'b1, 5'd9, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0, 3'b000);
    expect_now("ext_release", 2'd1, 2'd0, 1'b1, 3'd1);
    step(1'b1, 5'd9, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0, 3'b000);
    expect_now("ext_fwd", 2'd2, 2'd0, 1'b0, 3'd2);
    idle(3);

    // younger non-ready load shadows an older ready ALU write of x8
    step(1'b1, 5'd0, 5'd0, 2'b00, 5'd8, 1'b1, 2'd1, 1'b0, 3'b000);
    step(1'b1, 5'd0, 5'd0, 2'b00, 5'd8, 1'b1, 2'd2, 1'b0, 3'b000);
    step(1'b1, 5'd8, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0, 3'b000);
    expect_now("younger_decides", 2'd1, 2'd0, 1'b1, 3'd2);
    step(1'b1, 5'd8, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0, 3'b000);
    expect_now("younger_fwd", 2'd2, 2'd0, 1'b0, 3'd3);
    idle(3);

    // multi-cycle writer (ready in WB) stalls twice per use; counter saturates at 7
    c = 3;
    for (int j = 0; j < 3; j++) begin
      step(1'b1, 5'd0, 5'd0, 2'b00, 5'd11, 1'b1, 2'd3, 1'b0, 3'b000);
      step(1'b1, 5'd11, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0, 3'b000);
      expect_now("mc_stall_ex", 2'd1, 2'd0, 1'b1, sat(c));
      step(1'b1, 5'd11, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0, 3'b000);
      expect_now("mc_stall_mem", 2'd2, 2'd0, 1'b1, sat(c + 1));
      step(1'b1, 5'd11, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0, 3'b000);
      expect_now("mc_fwd_wb", 2'd3, 2'd0, 1'b0, sat(c + 2));
      c = c + 2;
      idle(3);
    end

    // mid-operation reset drops the in-flight load and clears the counter
    step(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 2'd2, 1'b0, 3'b000);
    rst_drv = 1'b1;
    idle(1);
    rst_drv = 1'b0;
    step(1'b1, 5'd9, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0, 3'b000);
    expect_now("mid_reset", 2'd0, 2'd0, 1'b0, 3'd0);

    for (int i = 0; i < 20 && q.size() > 0; i++)
      @(posedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
